// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundles the two master request channels, the shared
// memory-bus strobes and the debug status of the two-master bus arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives requests and supplies bus read data.
interface mem_bus_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_ack;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_ack;

    logic                  bus_re;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;

    logic                  owner;
    logic                  busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  bus_rdata,
        output m0_rdata, m0_ack, m1_rdata, m1_ack,
        output bus_re, bus_we, bus_addr, bus_wdata,
        output owner, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output bus_rdata,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack,
        input  bus_re, bus_we, bus_addr, bus_wdata,
        input  owner, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master arbiter for the single memory-mapped bus.
// Grants one access at a time, drives the bus for WAIT_CYCLES cycles from
// values latched at grant, then pulses the winner's ack for one cycle.
// Optional macro ARB_FIXED_PRIO_EN: master 0 always wins simultaneous
// requests; default (undefined) is round-robin on the last grant.
module mem_bus_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_CYCLES = 1
) (
    input logic clk,
    input logic rst,
    mem_bus_arbiter_if.slave arb
);
    localparam int CNT_WIDTH = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic any_req;
    logic grant_m1;
    logic final_cycle;

    assign final_cycle = (cnt_q == '0);

    // Pick the winner among the current requesters.
    always_comb begin
        any_req = arb.m0_req | arb.m1_req;
`ifdef ARB_FIXED_PRIO_EN
        grant_m1 = arb.m1_req & ~arb.m0_req;
`else
        grant_m1 = arb.m1_req & (~arb.m0_req | ~last_grant_q);
`endif
    end

    // Next-state logic: latch the winner's access at grant, count down the
    // bus cycles, capture read data on the last one, then acknowledge.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d      = BUSY;
                    owner_d      = grant_m1;
                    last_grant_d = grant_m1;
                    we_d         = grant_m1 ? arb.m1_we    : arb.m0_we;
                    addr_d       = grant_m1 ? arb.m1_addr  : arb.m0_addr;
                    wdata_d      = grant_m1 ? arb.m1_wdata : arb.m0_wdata;
                    cnt_d        = CNT_LOAD;
                end
            end
            BUSY: begin
                if (final_cycle) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q) begin
                            m1_rdata_d = arb.bus_rdata;
                        end else begin
                            m0_rdata_d = arb.bus_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; last_grant resets
    // to master 1 so master 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    // Writes strobe only in the last bus cycle so side-effecting peripherals
    // see a single write; reads hold the enable for the whole access.
    assign arb.bus_re    = (state_q == BUSY) & ~we_q;
    assign arb.bus_we    = (state_q == BUSY) & we_q & final_cycle;
    assign arb.bus_addr  = addr_q;
    assign arb.bus_wdata = wdata_q;
    assign arb.m0_ack    = (state_q == DONE) & ~owner_q;
    assign arb.m1_ack    = (state_q == DONE) & owner_q;
    assign arb.m0_rdata  = m0_rdata_q;
    assign arb.m1_rdata  = m1_rdata_q;
    assign arb.owner     = owner_q;
    assign arb.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: self-checking bench for mem_bus_arbiter.
// dut_a (WAIT_CYCLES=1) runs the single-read timing sequence; dut_b
// (WAIT_CYCLES=3) runs a vector table plus hand-written corner sequences,
// with expected transactions queued at drive time and checked on each ack.
module tb_mem_bus_arbiter;
    localparam int WB = 3;

    typedef struct {
        logic        r0;
        logic        we0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        r1;
        logic        we1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic        exp_owner;
    } vec_t;

    typedef struct {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] other_rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    int n_checks = 0;
    int n_pass = 0;
    exp_t sb[$];
    logic [31:0] exp_rd [2];
    vec_t tbl [8];

    mem_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifa ();
    mem_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifb ();

    mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_CYCLES(1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .arb (ifa.slave)
    );

    mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_CYCLES(WB)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .arb (ifb.slave)
    );

    function automatic logic [31:0] memB(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    assign ifa.bus_rdata = 32'hDEAD_BEEF;
    assign ifb.bus_rdata = memB(ifb.bus_addr);

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        n_checks++;
        $display("[TB] FAIL %s", name);
    endtask

    // Model of the read-data registers: updated when a read is queued.
    task automatic pushExp(input logic own, input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        if (!we) exp_rd[own] = memB(a);
        e.owner       = own;
        e.we          = we;
        e.addr        = a;
        e.wdata       = d;
        e.rdata       = exp_rd[own];
        e.other_rdata = exp_rd[!own];
        sb.push_back(e);
    endtask

    task automatic waitAck();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = ifb.m0_ack | ifb.m1_ack;
        end
        if (!got) failNow("ack_timeout");
    endtask

    // Watches dut_b's bus strobes and compares each acknowledged access
    // against the oldest queued expectation.
    task automatic monitorB();
        int re_cnt;
        int we_cnt;
        logic [31:0] seen_addr;
        logic [31:0] seen_wdata;
        exp_t e;
        re_cnt = 0;
        we_cnt = 0;
        seen_addr = '0;
        seen_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                re_cnt = 0;
                we_cnt = 0;
            end else begin
                if (ifb.bus_re) begin
                    re_cnt++;
                    seen_addr = ifb.bus_addr;
                end
                if (ifb.bus_we) begin
                    we_cnt++;
                    seen_addr = ifb.bus_addr;
                    seen_wdata = ifb.bus_wdata;
                end
                if (ifb.m0_ack || ifb.m1_ack) begin
                    if (sb.size() == 0) begin
                        failNow("unexpected_ack");
                    end else begin
                        e = sb.pop_front();
                        checkOutput("ack_pair", {30'd0, ifb.m1_ack, ifb.m0_ack}, e.owner ? 32'd2 : 32'd1);
                        checkOutput("owner", {31'd0, ifb.owner}, {31'd0, e.owner});
                        checkOutput("re_cycles", re_cnt, e.we ? 32'd0 : WB);
                        checkOutput("we_cycles", we_cnt, e.we ? 32'd1 : 32'd0);
                        checkOutput("bus_addr", seen_addr, e.addr);
                        if (e.we) checkOutput("bus_wdata", seen_wdata, e.wdata);
                        checkOutput("own_rdata", e.owner ? ifb.m1_rdata : ifb.m0_rdata, e.rdata);
                        checkOutput("other_rdata", e.owner ? ifb.m0_rdata : ifb.m1_rdata, e.other_rdata);
                    end
                    re_cnt = 0;
                    we_cnt = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic own;
        own = v.exp_owner;
        ifb.m0_req = v.r0;  ifb.m0_we = v.we0;  ifb.m0_addr = v.a0;  ifb.m0_wdata = v.d0;
        ifb.m1_req = v.r1;  ifb.m1_we = v.we1;  ifb.m1_addr = v.a1;  ifb.m1_wdata = v.d1;
        pushExp(own, own ? v.we1 : v.we0, own ? v.a1 : v.a0, own ? v.d1 : v.d0);
        waitAck();
        ifb.m0_req = 1'b0;
        ifb.m1_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t vc;
        logic we_seen;
        logic ack_seen;
        logic own;

        ifa.m0_req = 1'b0; ifa.m0_we = 1'b0; ifa.m0_addr = '0; ifa.m0_wdata = '0;
        ifa.m1_req = 1'b0; ifa.m1_we = 1'b0; ifa.m1_addr = '0; ifa.m1_wdata = '0;
        ifb.m0_req = 1'b0; ifb.m0_we = 1'b0; ifb.m0_addr = '0; ifb.m0_wdata = '0;
        ifb.m1_req = 1'b0; ifb.m1_we = 1'b0; ifb.m1_addr = '0; ifb.m1_wdata = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        tbl[0] = '{1'b1, 1'b0, 32'h0040_0000, 32'h0,  1'b0, 1'b0, 32'h0,         32'h0,        1'b0};
        tbl[1] = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b1, 32'h1001_0024, 32'h0000_00A5, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 32'h100,       32'h0,  1'b1, 1'b0, 32'h200,       32'h0,        1'b0};
        tbl[3] = '{1'b1, 1'b1, 32'h300,       32'h11, 1'b1, 1'b1, 32'h400,       32'h22,       1'b1};
        tbl[4] = '{1'b1, 1'b0, 32'h500,       32'h0,  1'b1, 1'b1, 32'h600,       32'h66,       1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h0040_0010, 32'hCAFE, 1'b0, 1'b0, 32'h0,       32'h0,        1'b0};
        tbl[6] = '{1'b1, 1'b0, 32'h700,       32'h0,  1'b1, 1'b0, 32'h800,       32'h0,        1'b1};
        tbl[7] = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        1'b1};
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].r0 && tbl[i].r1) tbl[i].exp_owner = 1'b0;
        end
`endif

        fork
            monitorB();
        join_none

        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset values.
        checkOutput("rst_busy", {31'd0, ifb.busy}, 32'd0);
        checkOutput("rst_owner", {31'd0, ifb.owner}, 32'd0);
        checkOutput("rst_acks", {30'd0, ifb.m1_ack, ifb.m0_ack}, 32'd0);
        checkOutput("rst_strobes", {30'd0, ifb.bus_we, ifb.bus_re}, 32'd0);
        checkOutput("rst_bus_addr", ifb.bus_addr, 32'd0);
        checkOutput("rst_bus_wdata", ifb.bus_wdata, 32'd0);
        checkOutput("rst_m0_rdata", ifb.m0_rdata, 32'd0);
        checkOutput("rst_m1_rdata", ifb.m1_rdata, 32'd0);

        // Single read on the WAIT_CYCLES=1 instance.
        ifa.m0_req = 1'b1; ifa.m0_we = 1'b0; ifa.m0_addr = 32'h0040_0000;
        @(negedge clk);
        checkOutput("a_re_n1", {31'd0, ifa.bus_re}, 32'd1);
        checkOutput("a_addr_n1", ifa.bus_addr, 32'h0040_0000);
        checkOutput("a_ack_n1", {31'd0, ifa.m0_ack}, 32'd0);
        @(negedge clk);
        checkOutput("a_re_n2", {31'd0, ifa.bus_re}, 32'd0);
        checkOutput("a_ack_n2", {31'd0, ifa.m0_ack}, 32'd1);
        checkOutput("a_rdata_n2", ifa.m0_rdata, 32'hDEAD_BEEF);
        checkOutput("a_m1_ack_n2", {31'd0, ifa.m1_ack}, 32'd0);
        ifa.m0_req = 1'b0;
        @(negedge clk);
        checkOutput("a_ack_n3", {31'd0, ifa.m0_ack}, 32'd0);
        checkOutput("a_busy_n3", {31'd0, ifa.busy}, 32'd0);

        // Vector table on the WAIT_CYCLES=3 instance.
        for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);

        // Latched signals: m0 changes addr/wdata mid-access; no re-grant in DONE.
        ifb.m0_req = 1'b1; ifb.m0_we = 1'b1; ifb.m0_addr = 32'h2000_0000; ifb.m0_wdata = 32'h1234_5678;
        pushExp(1'b0, 1'b1, 32'h2000_0000, 32'h1234_5678);
        @(negedge clk);
        ifb.m0_addr = 32'h3000_0000;
        ifb.m0_wdata = 32'h8765_4321;
        waitAck();
        checkOutput("latch_busy_done", {31'd0, ifb.busy}, 32'd1);
        @(negedge clk);
        checkOutput("latch_idle_after_done", {31'd0, ifb.busy}, 32'd0);
        ifb.m0_req = 1'b0;
        @(negedge clk);
        checkOutput("latch_no_regrant", {31'd0, ifb.busy}, 32'd0);

        // Early req drop: m1 abandons its read during BUSY.
        ifb.m1_req = 1'b1; ifb.m1_we = 1'b0; ifb.m1_addr = 32'h0000_1000;
        pushExp(1'b1, 1'b0, 32'h0000_1000, 32'h0);
        @(negedge clk);
        ifb.m1_req = 1'b0;
        waitAck();
        @(negedge clk);
        checkOutput("drop_idle", {31'd0, ifb.busy}, 32'd0);

        // Reset in the first BUSY cycle of a write.
        ifb.m0_req = 1'b1; ifb.m0_we = 1'b1; ifb.m0_addr = 32'h1001_0000; ifb.m0_wdata = 32'h55;
        @(negedge clk);
        checkOutput("rstmid_busy", {31'd0, ifb.busy}, 32'd1);
        checkOutput("rstmid_we_early", {31'd0, ifb.bus_we}, 32'd0);
        rst_b = 1'b1;
        ifb.m0_req = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        checkOutput("rstmid_idle", {31'd0, ifb.busy}, 32'd0);
        checkOutput("rstmid_acks", {30'd0, ifb.m1_ack, ifb.m0_ack}, 32'd0);
        we_seen = 1'b0;
        ack_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            we_seen = we_seen | ifb.bus_we;
            ack_seen = ack_seen | ifb.m0_ack | ifb.m1_ack;
        end
        checkOutput("rstmid_we_never", {31'd0, we_seen}, 32'd0);
        checkOutput("rstmid_ack_never", {31'd0, ack_seen}, 32'd0);
        vc = '{1'b1, 1'b0, 32'h0000_0900, 32'h0, 1'b1, 1'b0, 32'h0000_0A00, 32'h0, 1'b0};
        applyStimulus(vc);

        // Continuous contention from reset.
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        ifb.m0_req = 1'b1; ifb.m0_we = 1'b0; ifb.m0_addr = 32'h0000_0040;
        ifb.m1_req = 1'b1; ifb.m1_we = 1'b0; ifb.m1_addr = 32'h0000_0080;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            own = 1'b0;
`else
            own = k[0];
`endif
            pushExp(own, 1'b0, own ? 32'h0000_0080 : 32'h0000_0040, 32'h0);
        end
        for (int k = 0; k < 4; k++) waitAck();
        ifb.m0_req = 1'b0;
        ifb.m1_req = 1'b0;

        repeat (6) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
